// File: rtl/alu_pkg.sv
// Shared op codes, FSM states and op classification for the sequenced ALU.
// ALU_DIV_EN adds the divide op class and the DIV state.
package alu_pkg;

  localparam int unsigned ALU_AND  = 0;
  localparam int unsigned ALU_OR   = 1;
  localparam int unsigned ALU_ADD  = 2;
  localparam int unsigned ALU_SEQ  = 3;
  localparam int unsigned ALU_SGE  = 4;
  localparam int unsigned ALU_SGT  = 5;
  localparam int unsigned ALU_SUB  = 6;
  localparam int unsigned ALU_SLT  = 7;
  localparam int unsigned ALU_MUL  = 8;
  localparam int unsigned ALU_DIVU = 9;
  localparam int unsigned ALU_REMU = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DONE,
    ST_MUL
`ifdef ALU_DIV_EN
    ,
    ST_DIV
`endif
  } state_e;

  typedef enum logic [1:0] {
    OPC_SINGLE,
    OPC_MUL,
    OPC_DIV
  } op_class_e;

  // Without the divider, codes 9/10 fall through to the single-cycle class.
  function automatic op_class_e op_class(input int unsigned code);
    op_class_e c;
    c = OPC_SINGLE;
    if (code == ALU_MUL) c = OPC_MUL;
`ifdef ALU_DIV_EN
    if (code == ALU_DIVU || code == ALU_REMU) c = OPC_DIV;
`endif
    return c;
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// WIDTH-step shift-add multiplier sharing a 2*WIDTH accumulator and down-counter
// with a restoring divider (divider present only when ALU_DIV_EN is defined).
module alu_iter_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
`ifdef ALU_DIV_EN
  input  logic             div_i,
`endif
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             last_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic [WIDTH:0]     madd;
  logic [2*WIDTH-1:0] mul_step;

  assign madd     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_step = {madd, acc_q[WIDTH-1:1]};

`ifdef ALU_DIV_EN
  logic               div_q;
  logic [WIDTH:0]     rs;
  logic [WIDTH:0]     dsub;
  logic               qbit;
  logic [WIDTH-1:0]   rem;
  logic [2*WIDTH-1:0] div_step;

  // Shift remainder left by one dividend bit; a clear borrow means the trial subtract fits.
  assign rs       = acc_q[2*WIDTH-1:WIDTH-1];
  assign dsub     = rs - {1'b0, b_q};
  assign qbit     = ~dsub[WIDTH];
  assign rem      = qbit ? dsub[WIDTH-1:0] : rs[WIDTH-1:0];
  assign div_step = {rem, acc_q[WIDTH-2:0], qbit};
  assign acc_d    = div_q ? div_step : mul_step;
`else
  assign acc_d    = mul_step;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q  <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
`ifdef ALU_DIV_EN
      div_q  <= 1'b0;
`endif
    end else if (start_i) begin
      acc_q  <= {{WIDTH{1'b0}}, a_i};
      b_q    <= b_i;
      cnt_q  <= CNT_W'(WIDTH - 1);
      busy_q <= 1'b1;
`ifdef ALU_DIV_EN
      div_q  <= div_i;
`endif
    end else if (busy_q) begin
      acc_q <= acc_d;
      if (cnt_q == '0) busy_q <= 1'b0;
      else             cnt_q  <= cnt_q - 1'b1;
    end
  end

  // The owner captures the final step combinationally on the terminal-count edge.
  assign busy_o = busy_q;
  assign last_o = busy_q && (cnt_q == '0);
  assign lo_o   = acc_d[WIDTH-1:0];
  assign hi_o   = acc_d[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequenced ALU: registered single-cycle ops, iterative MUL, and
// iterative DIVU/REMU when ALU_DIV_EN is defined.
//   state   | meaning
//   IDLE    | ready for a new op
//   MUL     | multiplier stepping, inputs ignored
//   DIV     | divider stepping (ALU_DIV_EN only)
//   DONE    | result valid, held until out_ready_i
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WIDTH-1:0]  src1_i,
  input  logic [WIDTH-1:0]  src2_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WIDTH-1:0]  result_o,
  output logic [WIDTH-1:0]  hi_o,
  output logic              zero_o,
  output logic              ovf_o
);

  state_e           state_q;
  logic [WIDTH-1:0] result_q, hi_q;
  logic             zero_q, ovf_q, out_valid_q;

  int unsigned      code;
  op_class_e        opc;
  logic [WIDTH-1:0] sum, diff, res_d;
  logic             ovf_d;
  logic             mdu_start, mdu_busy, mdu_last;
  logic [WIDTH-1:0] mdu_lo, mdu_hi;

  assign code = 32'(ctrl_i);
  assign opc  = op_class(code);
  assign sum  = src1_i + src2_i;
  assign diff = src1_i - src2_i;

  always_comb begin
    res_d = '0;
    ovf_d = 1'b0;
    case (code)
      ALU_AND: res_d = src1_i & src2_i;
      ALU_OR:  res_d = src1_i | src2_i;
      ALU_ADD: begin
        res_d = sum;
        ovf_d = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) && (sum[WIDTH-1] != src1_i[WIDTH-1]);
      end
      ALU_SUB: begin
        res_d = diff;
        ovf_d = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) && (diff[WIDTH-1] != src1_i[WIDTH-1]);
      end
      ALU_SEQ: res_d = WIDTH'(src1_i == src2_i);
      ALU_SGE: res_d = WIDTH'($signed(src1_i) >= $signed(src2_i));
      ALU_SGT: res_d = WIDTH'($signed(src1_i) >  $signed(src2_i));
      ALU_SLT: res_d = WIDTH'($signed(src1_i) <  $signed(src2_i));
      default: res_d = '0;
    endcase
  end

  assign mdu_start = (state_q == ST_IDLE) && in_valid_i && (opc != OPC_SINGLE);

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (mdu_start),
`ifdef ALU_DIV_EN
    .div_i   (opc == OPC_DIV),
`endif
    .a_i     (src1_i),
    .b_i     (src2_i),
    .busy_o  (mdu_busy),
    .last_o  (mdu_last),
    .lo_o    (mdu_lo),
    .hi_o    (mdu_hi)
  );

`ifdef ALU_DIV_EN
  logic             rem_q;
  logic [WIDTH-1:0] div_res;
  assign div_res = rem_q ? mdu_hi : mdu_lo;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      hi_q        <= '0;
      zero_q      <= 1'b1;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef ALU_DIV_EN
      rem_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid_i) begin
            case (opc)
              OPC_MUL: state_q <= ST_MUL;
`ifdef ALU_DIV_EN
              OPC_DIV: begin
                state_q <= ST_DIV;
                rem_q   <= (code == ALU_REMU);
              end
`endif
              default: begin
                result_q    <= res_d;
                hi_q        <= '0;
                zero_q      <= (res_d == '0);
                ovf_q       <= ovf_d;
                out_valid_q <= 1'b1;
                state_q     <= ST_DONE;
              end
            endcase
          end
        end
        ST_MUL: begin
          if (mdu_busy && mdu_last) begin
            result_q    <= mdu_lo;
            hi_q        <= mdu_hi;
            zero_q      <= (mdu_lo == '0);
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
`ifdef ALU_DIV_EN
        ST_DIV: begin
          if (mdu_busy && mdu_last) begin
            result_q    <= div_res;
            hi_q        <= mdu_hi;
            zero_q      <= (div_res == '0);
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready_o  = (state_q == ST_IDLE);
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign hi_o        = hi_q;
  assign zero_o      = zero_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized plus directed bench for alu_seq against an arithmetic reference model.
module tb_alu_seq;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  src1, src2, result, hi;
  logic [3:0]    ctrl;
  logic          zero, ovf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W), .CTRL_W(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .src1_i      (src1),
    .src2_i      (src2),
    .ctrl_i      (ctrl),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result),
    .hi_o        (hi),
    .zero_o      (zero),
    .ovf_o       (ovf)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input int c, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic [W-1:0] h,
                                output logic v, output int lat);
    longint sa, sb, s;
    longint unsigned p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0; h = '0; v = 1'b0; lat = 0;
    case (c)
      0: r = a & b;
      1: r = a | b;
      2: begin s = sa + sb; r = W'(s); v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      3: r = (a == b) ? 1 : 0;
      4: r = (sa >= sb) ? 1 : 0;
      5: r = (sa > sb) ? 1 : 0;
      6: begin s = sa - sb; r = W'(s); v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      7: r = (sa < sb) ? 1 : 0;
      8: begin p = longint'(a) * longint'(b); r = p[31:0]; h = p[63:32]; lat = W; end
`ifdef ALU_DIV_EN
      9, 10: begin
        if (b == 0) begin r = '1; h = a; end
        else begin r = a / b; h = a % b; end
        if (c == 10) r = h;
        lat = W;
      end
`endif
      default: r = '0;
    endcase
  endfunction

  task automatic run_op(input int c, input logic [W-1:0] a, input logic [W-1:0] b, input int bp);
    logic [W-1:0] er, eh, r0, h0;
    logic ev, busy_ok, stable;
    int elat, lat;
    model(c, a, b, er, eh, ev, elat);
    @(negedge clk);
    check("ready_idle", in_ready, 1);
    ctrl = 4'(c); src1 = a; src2 = b; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; src1 = $urandom; src2 = $urandom; ctrl = 4'($urandom);
    lat = 0; busy_ok = 1'b1;
    while (!out_valid && lat < W + 5) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("latency c%0d", c), 64'(lat), 64'(elat));
    check("busy_not_ready", {busy_ok, in_ready}, 2'b10);
    check($sformatf("result c%0d", c), result, er);
    check($sformatf("hi c%0d", c), hi, eh);
    check($sformatf("zero c%0d", c), zero, er == 0);
    check($sformatf("ovf c%0d", c), ovf, ev);
    r0 = result; h0 = hi; stable = 1'b1;
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== r0 || hi !== h0 ||
          zero !== (er == 0) || ovf !== ev) stable = 1'b0;
    end
    if (bp > 0) check("backpressure_hold", stable, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release", {out_valid, in_ready}, 2'b01);
    out_ready = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, in_ready, 1);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_hi"}, hi, 0);
    check({tag, "_zero"}, zero, 1);
    check({tag, "_ovf"}, ovf, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    src1 = '0; src2 = '0; ctrl = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk); rst = 1'b0;

    run_op(2, 32'h7FFF_FFFF, 32'h1, 0);
    run_op(6, 32'd5, 32'd5, 0);
    run_op(6, 32'h8000_0000, 32'h1, 0);
    run_op(7, 32'hFFFF_FFFF, 32'h1, 0);
    run_op(4, 32'd3, 32'd3, 0);
    run_op(5, 32'd3, 32'd3, 0);
    run_op(15, 32'h1234, 32'h5678, 0);
    run_op(0, 32'hF0F0_1234, 32'h0FF0_FFFF, 1);
    run_op(1, 32'hF000_0000, 32'h0000_000F, 0);
    run_op(3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
    run_op(8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10);
    run_op(9, 32'd100, 32'd7, 0);
    run_op(10, 32'd100, 32'd7, 0);
    run_op(9, 32'h8765_4321, 32'd0, 0);
    run_op(10, 32'h8765_4321, 32'd0, 0);

    // Abort a multiply part-way through with a one-cycle reset pulse.
    @(negedge clk);
    ctrl = 4'd8; src1 = 32'hABCD; src2 = 32'h1234; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check_reset_state("midmul_reset");
    @(negedge clk); rst = 1'b0;
    repeat (W + 2) begin
      @(posedge clk); #1;
      if (out_valid) check("no_stale_result", out_valid, 0);
    end
    run_op(2, 32'd2, 32'd3, 0);

    for (int k = 0; k < 40; k++) begin
      logic [W-1:0] a, b;
      int sel;
      sel = int'($urandom_range(0, 5));
      a = $urandom; b = $urandom;
      if (sel == 0) b = a;
      if (sel == 1) b = '0;
      if (sel == 2) a = 32'h8000_0000;
      if (sel == 3) b = W'($urandom_range(1, 20));
      run_op(int'($urandom_range(0, 15)), a, b, int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
